// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: APB3 GPIO with synchronised, optionally debounced inputs and maskable edge/level interrupts
module gpio_irq_ctrl #(
  parameter int GPIO_DATA_WIDTH = 16,
  parameter int DB_DIV_WIDTH = 16
) (
  input  logic pclk,
  input  logic n_p_reset,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic [4:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic pready,
  output logic pslverr,
  input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in,
  output logic [GPIO_DATA_WIDTH-1:0] gpio_pin_out,
  output logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe,
  output logic gpio_irq
);
  localparam int W = GPIO_DATA_WIDTH;
  localparam int DW = DB_DIV_WIDTH;
  logic [W-1:0] data_out, oe_n, irq_mask, irq_edge, irq_pol, irq_status;
  logic [W-1:0] sync1, sync2, filt, filt_d, h1, h2, agree, ev_set, w1c;
  logic [DW-1:0] db_div, presc;
  logic [2:0] idx;
  logic [7:0] we;
  logic [31:0] rd_val;
  logic hit, tick;
  assign idx = paddr[4:2];
  assign we = {8{psel & penable & pwrite & hit}} & (8'd1 << idx);
  assign pready = 1'b1;
  assign pslverr = psel & penable & ~hit;
  assign prdata = (psel & ~pwrite) ? rd_val : 32'd0;
  assign gpio_pin_out = data_out;
  assign n_gpio_pin_oe = oe_n;
  always_comb begin
    hit = 1'b1;
    rd_val = 32'd0;
    case (idx)
      3'd0: rd_val = 32'(data_out);
      3'd1: rd_val = 32'(oe_n);
      3'd2: rd_val = 32'(filt);
      3'd3: rd_val = 32'(irq_mask);
      3'd4: rd_val = 32'(irq_edge);
      3'd5: rd_val = 32'(irq_pol);
      3'd6: rd_val = 32'(irq_status);
      3'd7: rd_val = 32'(db_div);
      default: hit = 1'b0;
    endcase
  end
  // filt only follows sync2 once three consecutive tick samples agree
  assign tick = (db_div != '0) && (presc == db_div);
  assign agree = ~(sync2 ^ h1) & ~(h1 ^ h2);
  assign ev_set = (irq_edge & ((irq_pol & filt & ~filt_d) | (~irq_pol & ~filt & filt_d)))
                | (~irq_edge & ~(filt ^ irq_pol));
  assign w1c = we[6] ? pwdata[W-1:0] : '0;
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      data_out <= '0;
      oe_n <= '1;
      irq_mask <= '0;
      irq_edge <= '0;
      irq_pol <= '0;
      irq_status <= '0;
      db_div <= '0;
      presc <= '0;
      sync1 <= '0;
      sync2 <= '0;
      filt <= '0;
      filt_d <= '0;
      h1 <= '0;
      h2 <= '0;
      gpio_irq <= 1'b0;
    end else begin
      if (we[0]) data_out <= pwdata[W-1:0];
      if (we[1]) oe_n <= pwdata[W-1:0];
      if (we[3]) irq_mask <= pwdata[W-1:0];
      if (we[4]) irq_edge <= pwdata[W-1:0];
      if (we[5]) irq_pol <= pwdata[W-1:0];
      if (we[7]) db_div <= pwdata[DW-1:0];
      presc <= (we[7] || tick || db_div == '0) ? '0 : presc + DW'(1);
      sync1 <= gpio_pin_in;
      sync2 <= sync1;
      if (tick) begin
        h1 <= sync2;
        h2 <= h1;
      end
      filt <= (db_div == '0) ? sync2 : tick ? (filt & ~agree) | (sync2 & agree) : filt;
      filt_d <= filt;
      irq_status <= (irq_status & ~w1c) | ev_set;
      gpio_irq <= |(irq_status & irq_mask);
    end
  end
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl: random and directed APB/pin stimulus against a per-pin reference model, scoreboard-checked
module tb_gpio_irq_ctrl;
  localparam int W = 16;
  logic pclk = 1'b0, n_p_reset = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic pready, pslverr, gpio_irq;
  logic [W-1:0] gpio_pin_in = '0, gpio_pin_out, n_gpio_pin_oe;

  gpio_irq_ctrl #(.GPIO_DATA_WIDTH(W), .DB_DIV_WIDTH(16)) dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .gpio_pin_in(gpio_pin_in), .gpio_pin_out(gpio_pin_out), .n_gpio_pin_oe(n_gpio_pin_oe),
    .gpio_irq(gpio_irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit rd;
    logic [31:0] prd;
    logic [W-1:0] pout;
    logic [W-1:0] poe;
    logic irq;
  } exp_t;
  exp_t exp_q[$];
  event chk_ev;
  int n_tests = 0, n_fail = 0;

  logic [W-1:0] m_dout, m_oen, m_mask, m_edge, m_pol, m_stat, m_s1, m_s2, m_filt, m_filt_d;
  logic [W-1:0] m_hist[$];
  logic m_irq;
  int m_div, m_cnt;

  task automatic model_reset();
    m_dout = '0; m_oen = '1; m_mask = '0; m_edge = '0; m_pol = '0; m_stat = '0;
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_filt_d = '0; m_irq = 1'b0; m_div = 0; m_cnt = 0;
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
  endtask

  // one clock edge of the device as described pin by pin, using the inputs present at the edge
  task automatic model_step();
    logic [W-1:0] n_stat, n_filt;
    bit wr, tick, ev;
    int idx;
    if (!n_p_reset) begin
      model_reset();
      return;
    end
    wr = psel && penable && pwrite;
    idx = int'(paddr[4:2]);
    tick = m_div != 0 && m_cnt == m_div;
    for (int i = 0; i < W; i++) begin
      if (m_edge[i]) ev = m_pol[i] ? (m_filt[i] && !m_filt_d[i]) : (!m_filt[i] && m_filt_d[i]);
      else ev = (m_filt[i] == m_pol[i]);
      n_stat[i] = ev || (m_stat[i] && !(wr && idx == 6 && pwdata[i]));
      if (m_div == 0) n_filt[i] = m_s2[i];
      else if (tick && m_s2[i] == m_hist[0][i] && m_s2[i] == m_hist[1][i]) n_filt[i] = m_s2[i];
      else n_filt[i] = m_filt[i];
    end
    m_irq = (m_stat & m_mask) != '0;
    m_stat = n_stat;
    if (tick) begin
      m_hist.push_front(m_s2);
      void'(m_hist.pop_back());
    end
    m_cnt = ((wr && idx == 7) || tick || m_div == 0) ? 0 : m_cnt + 1;
    m_filt_d = m_filt;
    m_filt = n_filt;
    m_s2 = m_s1;
    m_s1 = gpio_pin_in;
    if (wr) begin
      case (idx)
        0: m_dout = pwdata[W-1:0];
        1: m_oen = pwdata[W-1:0];
        3: m_mask = pwdata[W-1:0];
        4: m_edge = pwdata[W-1:0];
        5: m_pol = pwdata[W-1:0];
        7: m_div = int'(pwdata[15:0]);
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_dout);
      3'd1: return 32'(m_oen);
      3'd2: return 32'(m_filt);
      3'd3: return 32'(m_mask);
      3'd4: return 32'(m_edge);
      3'd5: return 32'(m_pol);
      3'd6: return 32'(m_stat);
      default: return 32'(m_div);
    endcase
  endfunction

  task automatic push_exp(input bit rd, input logic [4:0] a);
    exp_t e;
    e.rd = rd;
    e.prd = rd_model(a[4:2]);
    e.pout = m_dout;
    e.poe = m_oen;
    e.irq = m_irq;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit ps, input bit pe, input bit pw, input logic [4:0] a, input logic [31:0] d);
    @(posedge pclk);
    model_step();
    #1;
    psel = ps; penable = pe; pwrite = pw; paddr = a; pwdata = d;
    push_exp(ps && pe && !pw, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr_t(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, 1'b1, a, d);
    cyc(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_t(input logic [4:0] a);
    cyc(1'b1, 1'b0, 1'b0, a, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, a, 32'd0);
  endtask

  // combinational check while reset is held, independent of any clock edge
  task automatic async_chk(input logic [4:0] a);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    push_exp(1'b1, a);
    ->chk_ev;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge pclk or chk_ev);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gpio_pin_out", 32'(gpio_pin_out), 32'(e.pout));
      chk("n_gpio_pin_oe", 32'(n_gpio_pin_oe), 32'(e.poe));
      chk("gpio_irq", 32'(gpio_irq), 32'(e.irq));
      chk("pready_pslverr", {30'd0, pready, pslverr}, 32'd2);
      if (e.rd) chk("prdata", prdata, e.prd);
    end
  end

  initial begin
    gpio_pin_in = 16'h0001;
    #1 n_p_reset = 1'b0;
    model_reset();
    async_chk(5'h04);
    async_chk(5'h00);
    async_chk(5'h18);
    psel = 1'b0;
    idle(3);
    n_p_reset = 1'b1;
    idle(4);
    rd_t(5'h18);
    wr_t(5'h18, 32'h1);
    rd_t(5'h18);
    wr_t(5'h00, 32'hA5A5);
    idle(1);
    wr_t(5'h04, 32'hFF00);
    idle(1);
    rd_t(5'h00);
    rd_t(5'h05);
    rd_t(5'h0B);
    wr_t(5'h10, 32'h8);
    wr_t(5'h14, 32'h8);
    wr_t(5'h0C, 32'h8);
    wr_t(5'h18, 32'hFFFF);
    idle(2);
    gpio_pin_in[3] = 1'b1;
    idle(6);
    rd_t(5'h08);
    wr_t(5'h18, 32'h8);
    idle(3);
    wr_t(5'h0C, 32'h28);
    idle(3);
    wr_t(5'h18, 32'h20);
    idle(1);
    rd_t(5'h18);
    gpio_pin_in[5] = 1'b1;
    idle(4);
    wr_t(5'h18, 32'h20);
    idle(3);
    rd_t(5'h18);
    wr_t(5'h10, 32'h9);
    wr_t(5'h14, 32'h9);
    gpio_pin_in[0] = 1'b0;
    wr_t(5'h1C, 32'h3);
    idle(20);
    wr_t(5'h18, 32'h1);
    gpio_pin_in[0] = 1'b1;
    idle(6);
    gpio_pin_in[0] = 1'b0;
    idle(14);
    rd_t(5'h08);
    rd_t(5'h18);
    gpio_pin_in[0] = 1'b1;
    idle(16);
    rd_t(5'h08);
    rd_t(5'h18);
    for (int k = 0; k < 150; k++) begin
      logic [4:0] a;
      logic [31:0] d;
      int op;
      a = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d = $urandom;
      if (a[4:2] == 3'd7) d = $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) gpio_pin_in = gpio_pin_in ^ (W'(1) << $urandom_range(0, W - 1));
      if (op == 0) wr_t(a, d);
      else if (op == 1) rd_t(a);
      else idle($urandom_range(1, 4));
    end
    wr_t(5'h1C, 32'h3);
    wr_t(5'h0C, 32'hFFFF);
    gpio_pin_in = 16'h5A3C;
    idle(5);
    @(negedge pclk);
    #2;
    n_p_reset = 1'b0;
    model_reset();
    async_chk(5'h04);
    async_chk(5'h18);
    async_chk(5'h1C);
    psel = 1'b0;
    idle(2);
    n_p_reset = 1'b1;
    idle(6);
    rd_t(5'h08);
    rd_t(5'h18);
    rd_t(5'h1C);
    idle(2);
    @(negedge pclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
